// File: rtl/cipher_pkg.sv
// Shared definitions for the rotate-XOR cipher: FSM states, mode constants, 8-bit rotates.
// The encrypter imports this same package so both ends rotate identically.
package cipher_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic MODE_SIMPLE   = 1'b0;
  localparam logic MODE_IMPROVED = 1'b1;

  // Doubling the byte makes the wrap-around bits fall out of a plain shift.
  function automatic logic [7:0] rol8(input logic [7:0] d, input logic [2:0] s);
    logic [15:0] t;
    t = {d, d} << s;
    return t[15:8];
  endfunction

  function automatic logic [7:0] ror8(input logic [7:0] d, input logic [2:0] s);
    logic [15:0] t;
    t = {d, d} >> s;
    return t[7:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags, write-while-full when popping, and flush.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/xor_decrypter_rx.sv
// Receive-side rotate-XOR decrypter: UART_RX bytes in, plaintext out through a
// show-ahead FIFO with valid/ready, in simple or chained-key mode.
module xor_decrypter_rx
  import cipher_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Enable,
  input  logic [7:0]           i_Key,
  input  logic [2:0]           i_Shift,
  input  logic                 i_Improved_En,
  input  logic                 i_Last_Data,
  input  logic                 i_RX_DV,
  input  logic [7:0]           i_RX_Byte,
  input  logic                 i_Data_Ready,
  output logic                 o_Data_DV,
  output logic [7:0]           o_Data_Byte,
  output logic [CNT_WIDTH-1:0] o_Byte_Count,
  output logic                 o_Overflow,
  output logic                 o_Busy,
  output logic                 o_Complete
);

  state_t               state, next_state;
  logic                 enable_q;
  logic [7:0]           key_q;
  logic [2:0]           shift_q;
  logic                 mode_q;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;

  logic       start;
  logic       rx_take;
  logic       pop;
  logic       wr_accept;
  logic       drop;
  logic       flush;
  logic [7:0] plain;
  logic [7:0] fifo_head;
  logic       fifo_full;
  logic       fifo_empty;

  assign start     = i_Enable && !enable_q;
  assign rx_take   = (state == ST_ACTIVE) && i_Enable && i_RX_DV;
  assign pop       = i_Data_Ready && !fifo_empty;
  assign wr_accept = rx_take && (!fifo_full || pop);
  assign drop      = rx_take && fifo_full && !pop;
  assign flush     = ((state == ST_ACTIVE) || (state == ST_DRAIN)) && !i_Enable;
  assign plain     = ror8(i_RX_Byte, shift_q) ^ key_q;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (i_Clock),
    .rst_n   (i_Rst_n),
    .flush   (flush),
    .wr_en   (wr_accept),
    .wr_data (plain),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ST_IDLE:   if (start) next_state = ST_ACTIVE;
      ST_ACTIVE: begin
        if (!i_Enable)                     next_state = ST_IDLE;
        else if (i_RX_DV && i_Last_Data)   next_state = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!i_Enable)       next_state = ST_IDLE;
        else if (fifo_empty) next_state = ST_DONE;
      end
      ST_DONE:   if (!i_Enable) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // Reset loads the live enable so a level held high through reset is not a new session.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      enable_q <= i_Enable;
      key_q    <= '0;
      shift_q  <= '0;
      mode_q   <= MODE_SIMPLE;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      enable_q <= i_Enable;
      if (state == ST_IDLE && start) begin
        key_q    <= i_Key;
        shift_q  <= i_Shift;
        mode_q   <= i_Improved_En;
        count    <= '0;
        overflow <= 1'b0;
      end else begin
        if (rx_take && mode_q == MODE_IMPROVED) key_q <= i_RX_Byte;
        if (wr_accept && count != '1)           count <= count + CNT_WIDTH'(1);
        if (drop)                               overflow <= 1'b1;
      end
    end
  end

  assign o_Data_DV    = !fifo_empty;
  assign o_Data_Byte  = fifo_empty ? 8'h00 : fifo_head;
  assign o_Byte_Count = count;
  assign o_Overflow   = overflow;
  assign o_Busy       = (state == ST_ACTIVE) || (state == ST_DRAIN);
  assign o_Complete   = (state == ST_DONE);

endmodule
